// File: rtl/mem_arbiter.sv
// Two-requester arbiter (instruction fetch, load/store) in front of one single-port memory.
// Optional access timeout with sticky err flag is enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_arbiter #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_done,
    input  logic [1:0]        ls_req,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    output logic [DATA_W-1:0] ls_rdata,
    output logic              ls_done,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              busy,
    output logic              grant,
    output logic              err
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("mem_arbiter: TIMEOUT must be at least 1");
    end

    state_e            state_q, state_d;
    logic              owner_q, owner_d;   // 0 = fetch, 1 = load/store
    logic              rr_q, rr_d;         // 1 = next tie goes to load/store
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] ls_rdata_q, ls_rdata_d;

    logic ls_load, ls_store, ls_valid, pick_ls;
    assign ls_load  = (ls_req == 2'b01);
    assign ls_store = (ls_req == 2'b10);
    assign ls_valid = ls_load | ls_store;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
`endif

    // NOTE: every always_comb target gets its default first, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        rr_d       = rr_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        if_rdata_d = if_rdata_q;
        ls_rdata_d = ls_rdata_q;
        pick_ls    = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
        cnt_d      = cnt_q;
        err_d      = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (if_req || ls_valid) begin
                    pick_ls = ls_valid && (!if_req || rr_q);
                    owner_d = pick_ls;
                    addr_d  = pick_ls ? ls_addr : if_addr;
                    wdata_d = pick_ls ? ls_wdata : '0;
                    we_d    = pick_ls && ls_store;
                    state_d = ACCESS;
`ifdef MEM_ARB_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            ACCESS: begin
                if (mem_ack) begin
                    if (!we_q) begin
                        if (owner_q) ls_rdata_d = mem_rdata;
                        else         if_rdata_d = mem_rdata;
                    end
                    state_d = RESP;
                end
`ifdef MEM_ARB_TIMEOUT_EN
                // An ack on the limit cycle takes precedence over the timeout.
                else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            RESP: begin
                rr_d    = ~owner_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            owner_q    <= 1'b0;
            rr_q       <= 1'b1;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            if_rdata_q <= '0;
            ls_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            rr_q       <= rr_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            if_rdata_q <= if_rdata_d;
            ls_rdata_q <= ls_rdata_d;
        end
    end

`ifdef MEM_ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    logic in_access, in_resp;
    assign in_access = (state_q == ACCESS);
    assign in_resp   = (state_q == RESP);

    assign mem_en    = in_access;
    assign mem_we    = in_access && we_q;
    assign mem_addr  = in_access ? addr_q : '0;
    assign mem_wdata = in_access ? wdata_q : '0;
    assign if_done   = in_resp && !owner_q;
    assign ls_done   = in_resp && owner_q;
    assign busy      = (state_q != IDLE);
    assign grant     = owner_q;
    assign if_rdata  = if_rdata_q;
    assign ls_rdata  = ls_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter; the bench plays the memory and drives mem_ack.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_mem_arbiter;

    localparam int ADDR_W  = 8;
    localparam int DATA_W  = 16;
    localparam int TIMEOUT = 15;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              if_req = 1'b0;
    logic [ADDR_W-1:0] if_addr = '0;
    logic [DATA_W-1:0] if_rdata;
    logic              if_done;
    logic [1:0]        ls_req = 2'b00;
    logic [ADDR_W-1:0] ls_addr = '0;
    logic [DATA_W-1:0] ls_wdata = '0;
    logic [DATA_W-1:0] ls_rdata;
    logic              ls_done;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata = '0;
    logic              mem_ack = 1'b0;
    logic              busy;
    logic              grant;
    logic              err;

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
        .ls_req(ls_req), .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_rdata(ls_rdata),
        .ls_done(ls_done),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .busy(busy), .grant(grant), .err(err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int overlap = 0;

    always @(negedge clk) if (if_done && ls_done) overlap++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Waits (bounded) for the access to start, checks the bus for lat cycles, acks on the
    // last one, then checks the done pulse. Returns on the falling edge of the RESP cycle.
    task automatic run_access(input string tag, input int lat, input logic [DATA_W-1:0] rdata,
                              input logic exp_owner, input logic [ADDR_W-1:0] exp_addr,
                              input logic exp_we, input logic [DATA_W-1:0] exp_wdata);
        int waited = 0;
        while (!mem_en && waited < 8) begin
            @(negedge clk);
            waited++;
        end
        if (!mem_en) begin
            check({tag, "_start_timeout"}, 32'(mem_en), 32'd1);
        end else begin
            check({tag, "_grant"}, 32'(grant), 32'(exp_owner));
            for (int c = 1; c <= lat; c++) begin
                check({tag, "_en"}, 32'(mem_en), 32'd1);
                check({tag, "_we"}, 32'(mem_we), 32'(exp_we));
                check({tag, "_addr"}, 32'(mem_addr), 32'(exp_addr));
                if (exp_we) check({tag, "_wdata"}, 32'(mem_wdata), 32'(exp_wdata));
                if (c == lat) begin
                    mem_ack   = 1'b1;
                    mem_rdata = rdata;
                end
                @(negedge clk);
            end
            mem_ack   = 1'b0;
            mem_rdata = '0;
            check({tag, "_done"}, 32'({if_done, ls_done}), exp_owner ? 32'd1 : 32'd2);
            check({tag, "_en_resp"}, 32'(mem_en), 32'd0);
        end
    endtask

    initial begin
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_en", 32'({mem_en, mem_we}), 32'd0);
        check("rst_addr", 32'(mem_addr), 32'd0);
        check("rst_rdata", 32'({if_rdata, ls_rdata}), 32'd0);
        check("rst_flags", 32'({grant, err, if_done, ls_done}), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // Fetch only, single-cycle ack
        if_req  = 1'b1;
        if_addr = 8'h10;
        @(negedge clk);
        check("fetch_latency_en", 32'(mem_en), 32'd1);
        run_access("fetch", 1, 16'hA5C3, 1'b0, 8'h10, 1'b0, 16'h0);
        check("fetch_rdata", 32'(if_rdata), 32'hA5C3);
        if_req = 1'b0;
        @(negedge clk);
        check("fetch_idle", 32'({busy, if_done}), 32'd0);

        // Reapply reset so the first tie exercises the reset pointer
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // Tie with both held: load/store, fetch, load/store, fetch
        if_req   = 1'b1;
        if_addr  = 8'h40;
        ls_req   = 2'b01;
        ls_addr  = 8'h30;
        ls_wdata = 16'h9999;
        run_access("tie1", 1, 16'h1111, 1'b1, 8'h30, 1'b0, 16'h0);
        check("tie1_rdata", 32'(ls_rdata), 32'h1111);
        run_access("tie2", 2, 16'h2222, 1'b0, 8'h40, 1'b0, 16'h0);
        check("tie2_rdata", 32'(if_rdata), 32'h2222);
        run_access("tie3", 1, 16'h3333, 1'b1, 8'h30, 1'b0, 16'h0);
        check("tie3_rdata", 32'(ls_rdata), 32'h3333);
        run_access("tie4", 1, 16'h4444, 1'b0, 8'h40, 1'b0, 16'h0);
        check("tie4_rdata", 32'(if_rdata), 32'h4444);
        check("tie4_ls_hold", 32'(ls_rdata), 32'h3333);
        if_req = 1'b0;
        ls_req = 2'b00;
        @(negedge clk);
        check("tie_idle", 32'(busy), 32'd0);

        // Store with 3-cycle memory latency
        ls_req   = 2'b10;
        ls_addr  = 8'h22;
        ls_wdata = 16'h1234;
        run_access("store", 3, 16'hDEAD, 1'b1, 8'h22, 1'b1, 16'h1234);
        check("store_ls_rdata", 32'(ls_rdata), 32'h3333);
        ls_req = 2'b00;
        @(negedge clk);
        check("store_idle", 32'({busy, mem_we, ls_done}), 32'd0);

        // Invalid load/store code is not a request
        ls_req = 2'b11;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("ls11_idle", 32'({busy, mem_en}), 32'd0);
        end
        check("ls11_grant", 32'(grant), 32'd1);
        ls_req = 2'b00;

        // Memory never acknowledges
        if_req  = 1'b1;
        if_addr = 8'h55;
        @(negedge clk);
`ifdef MEM_ARB_TIMEOUT_EN
        begin
            int cycles = 0;
            while (mem_en && cycles < 40) begin
                cycles++;
                @(negedge clk);
            end
            check("to_cycles", 32'(cycles), 32'(TIMEOUT));
            check("to_done", 32'({if_done, ls_done}), 32'd2);
            check("to_err", 32'(err), 32'd1);
            check("to_rdata_hold", 32'(if_rdata), 32'h4444);
            if_req = 1'b0;
            repeat (3) @(negedge clk);
            check("to_err_sticky", 32'({err, busy}), 32'd2);
            if_req = 1'b1;
            @(negedge clk);
        end
`else
        repeat (40) @(negedge clk);
        check("noack_busy", 32'({busy, mem_en}), 32'd3);
        check("noack_err", 32'({err, if_done}), 32'd0);
`endif

        // Asynchronous reset in the middle of an access
        check("rst_mid_pre", 32'(mem_en), 32'd1);
        reset = 1'b0;
        #1;
        check("rst_mid_bus", 32'({mem_en, mem_we, busy}), 32'd0);
        check("rst_mid_addr", 32'(mem_addr), 32'd0);
        check("rst_mid_rdata", 32'({if_rdata, ls_rdata}), 32'd0);
        check("rst_mid_flags", 32'({grant, err, if_done, ls_done}), 32'd0);
        if_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("post_rst_idle", 32'({busy, mem_en, if_done, ls_done}), 32'd0);
        end

        check("no_done_overlap", 32'(overlap), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
